// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: main sequencing FSM plus ALU function decoder.
// Drives ALU opcode, datapath mux selects and write enables; consumes the ALU zero flag.
// Build option: define MIPS_CTRL_BNE_EN to decode opcode 000101 (bne) into the BNE state;
// without it, 000101 is treated as an unsupported opcode.
//
// state  | meaning
// -------+-----------------------------------------------------------
// FETCH  | read instruction at PC into IR, PC <= PC + 4 (waits MEM_WAIT)
// DECODE | read register file, precompute branch target into ALUOut
// MEMADR | compute lw/sw effective address
// MEMRD  | read data memory at ALUOut (waits MEM_WAIT)
// MEMWB  | write loaded word to rt
// MEMWR  | write reg B to data memory at ALUOut (waits MEM_WAIT)
// REXEC  | execute R-type operation
// ALUWB  | write ALU result to rd
// BEQ    | compare A - B, take branch on zero
// ADDIEX | compute A + signext(imm)
// ADDIWB | write addi result to rt
// JUMP   | load jump target into PC
// BNE    | compare A - B, take branch on non-zero
module mips_multicycle_ctrl #(
   parameter int unsigned MEM_WAIT = 0
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic [5:0] i_opcode,
   input  logic [5:0] i_funct,
   input  logic       i_zero_flag,
   output logic [2:0] o_alu_control,
   output logic       o_alu_src_a,
   output logic [1:0] o_alu_src_b,
   output logic [1:0] o_pc_src,
   output logic       o_iord,
   output logic       o_reg_dst,
   output logic       o_mem_to_reg,
   output logic       o_ir_write,
   output logic       o_mem_write,
   output logic       o_reg_write,
   output logic       o_pc_en,
   output logic       o_illegal_op,
   output logic [3:0] o_state
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_REXEC  = 4'd6,
      S_ALUWB  = 4'd7,
      S_BEQ    = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11,
      S_BNE    = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_CTRL_BNE_EN
   localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_NU  = 3'b011;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [3:0] LP_WAIT = MEM_WAIT[3:0];

   state_t     r_state;
   logic [3:0] r_wait;
   logic       w_wait_done;
   logic       w_legal;
   logic       w_pc_write;
   logic       w_beq;
   logic       w_bne;
   state_t     w_state_eff;

   assign w_wait_done = (r_wait == LP_WAIT);
   assign o_state     = r_state;

   // Classify the IR opcode as supported or not.
   always_comb begin
      w_legal = 1'b0;
      case (i_opcode)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: w_legal = 1'b1;
`ifdef MIPS_CTRL_BNE_EN
         OP_BNE:                                        w_legal = 1'b1;
`endif
         default:                                       w_legal = 1'b0;
      endcase
   end

   // State register and memory wait counter; the counter idles at zero so every
   // wait state is entered with a cleared count.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state <= S_FETCH;
         r_wait  <= '0;
      end else begin
         r_wait <= '0;
         case (r_state)
            S_FETCH:
               if (w_wait_done) r_state <= S_DECODE;
               else             r_wait  <= r_wait + 4'd1;
            S_DECODE:
               case (i_opcode)
                  OP_RTYPE:     r_state <= S_REXEC;
                  OP_LW, OP_SW: r_state <= S_MEMADR;
                  OP_BEQ:       r_state <= S_BEQ;
                  OP_ADDI:      r_state <= S_ADDIEX;
                  OP_J:         r_state <= S_JUMP;
`ifdef MIPS_CTRL_BNE_EN
                  OP_BNE:       r_state <= S_BNE;
`endif
                  default:      r_state <= S_FETCH;
               endcase
            S_MEMADR: r_state <= (i_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:
               if (w_wait_done) r_state <= S_MEMWB;
               else             r_wait  <= r_wait + 4'd1;
            S_MEMWR:
               if (w_wait_done) r_state <= S_FETCH;
               else             r_wait  <= r_wait + 4'd1;
            S_REXEC:  r_state <= S_ALUWB;
            S_ADDIEX: r_state <= S_ADDIWB;
            default:  r_state <= S_FETCH;
         endcase
      end
   end

   // Moore output decode; while reset is held the selects look like FETCH and
   // every enable is forced low so an aborted instruction cannot commit.
   always_comb begin
      w_state_eff   = i_reset_n ? r_state : S_FETCH;
      o_alu_control = ALU_AND;
      o_alu_src_a   = 1'b0;
      o_alu_src_b   = 2'b00;
      o_pc_src      = 2'b00;
      o_iord        = 1'b0;
      o_reg_dst     = 1'b0;
      o_mem_to_reg  = 1'b0;
      o_ir_write    = 1'b0;
      o_mem_write   = 1'b0;
      o_reg_write   = 1'b0;
      o_illegal_op  = 1'b0;
      w_pc_write    = 1'b0;
      w_beq         = 1'b0;
      w_bne         = 1'b0;
      case (w_state_eff)
         S_FETCH: begin
            o_alu_src_b   = 2'b01;
            o_alu_control = ALU_ADD;
            o_ir_write    = w_wait_done;
            w_pc_write    = w_wait_done;
         end
         S_DECODE: begin
            o_alu_src_b   = 2'b11;
            o_alu_control = ALU_ADD;
            o_illegal_op  = ~w_legal;
         end
         S_MEMADR, S_ADDIEX: begin
            o_alu_src_a   = 1'b1;
            o_alu_src_b   = 2'b10;
            o_alu_control = ALU_ADD;
         end
         S_MEMRD: o_iord = 1'b1;
         S_MEMWR: begin
            o_iord      = 1'b1;
            o_mem_write = 1'b1;
         end
         S_MEMWB: begin
            o_reg_write  = 1'b1;
            o_mem_to_reg = 1'b1;
         end
         S_REXEC: begin
            o_alu_src_a = 1'b1;
            case (i_funct)
               6'b100000: o_alu_control = ALU_ADD;
               6'b100010: o_alu_control = ALU_SUB;
               6'b100100: o_alu_control = ALU_AND;
               6'b100101: o_alu_control = ALU_OR;
               6'b101010: o_alu_control = ALU_SLT;
               default:   o_alu_control = ALU_NU;
            endcase
         end
         S_ALUWB: begin
            o_reg_write = 1'b1;
            o_reg_dst   = 1'b1;
         end
         S_ADDIWB: o_reg_write = 1'b1;
         S_BEQ, S_BNE: begin
            o_alu_src_a   = 1'b1;
            o_alu_control = ALU_SUB;
            o_pc_src      = 2'b01;
            w_beq         = (w_state_eff == S_BEQ);
            w_bne         = (w_state_eff == S_BNE);
         end
         S_JUMP: begin
            o_pc_src   = 2'b10;
            w_pc_write = 1'b1;
         end
         default: ;
      endcase
      o_pc_en = w_pc_write | (w_beq & i_zero_flag) | (w_bne & ~i_zero_flag);
      if (!i_reset_n) begin
         o_ir_write   = 1'b0;
         o_mem_write  = 1'b0;
         o_reg_write  = 1'b0;
         o_illegal_op = 1'b0;
         o_pc_en      = 1'b0;
      end
   end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Testbench for mips_multicycle_ctrl: two instances (MEM_WAIT 0 and 2) exercised in turn.
// Each instruction is expanded into its expected cycle-by-cycle phase list, and every
// cycle's outputs are compared against the rule table for that phase.
module tb_mips_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst0, rst2;
   logic [5:0] opcode, funct;
   logic       zero;

   logic [2:0] alu0, alu2;
   logic       sa0, sa2;
   logic [1:0] sb0, sb2, ps0, ps2;
   logic       iord0, iord2, rd0, rd2, m2r0, m2r2, irw0, irw2;
   logic       mw0, mw2, rw0, rw2, pce0, pce2, ill0, ill2;
   logic [3:0] st0, st2;
   logic [19:0] out0, out2;

   int n_cmp = 0;
   int n_err = 0;
   bit sel = 1'b0;
   int q_st[$];
   bit q_last[$];

   always #5 clk = ~clk;

   assign out0 = {alu0, sa0, sb0, ps0, iord0, rd0, m2r0, irw0, mw0, rw0, pce0, ill0, st0};
   assign out2 = {alu2, sa2, sb2, ps2, iord2, rd2, m2r2, irw2, mw2, rw2, pce2, ill2, st2};

   mips_multicycle_ctrl #(.MEM_WAIT(0)) u_dut0 (
      .i_clk(clk), .i_reset_n(rst0), .i_opcode(opcode), .i_funct(funct),
      .i_zero_flag(zero), .o_alu_control(alu0), .o_alu_src_a(sa0), .o_alu_src_b(sb0),
      .o_pc_src(ps0), .o_iord(iord0), .o_reg_dst(rd0), .o_mem_to_reg(m2r0),
      .o_ir_write(irw0), .o_mem_write(mw0), .o_reg_write(rw0), .o_pc_en(pce0),
      .o_illegal_op(ill0), .o_state(st0)
   );

   mips_multicycle_ctrl #(.MEM_WAIT(2)) u_dut2 (
      .i_clk(clk), .i_reset_n(rst2), .i_opcode(opcode), .i_funct(funct),
      .i_zero_flag(zero), .o_alu_control(alu2), .o_alu_src_a(sa2), .o_alu_src_b(sb2),
      .o_pc_src(ps2), .o_iord(iord2), .o_reg_dst(rd2), .o_mem_to_reg(m2r2),
      .o_ir_write(irw2), .o_mem_write(mw2), .o_reg_write(rw2), .o_pc_en(pce2),
      .o_illegal_op(ill2), .o_state(st2)
   );

   task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %05h expected %05h", tag, got, exp);
      end
   endtask

   function automatic bit is_legal(input logic [5:0] op);
      bit ok;
      ok = (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) || (op == 6'h04) ||
           (op == 6'h08) || (op == 6'h02);
`ifdef MIPS_CTRL_BNE_EN
      ok = ok || (op == 6'h05);
`endif
      return ok;
   endfunction

   function automatic logic [2:0] funct_alu(input logic [5:0] fn);
      case (fn)
         6'h20:   return 3'b010;
         6'h22:   return 3'b110;
         6'h24:   return 3'b000;
         6'h25:   return 3'b001;
         6'h2A:   return 3'b111;
         default: return 3'b011;
      endcase
   endfunction

   // Expected outputs for one cycle of a given phase.
   function automatic logic [19:0] exp_vec(input int st, input bit last, input logic [5:0] op,
                                           input logic [5:0] fn, input logic z, input bit in_rst);
      logic [2:0] alu;
      logic       sa, iord, rd, m2r, irw, mwr, rw, pcw, pce, ill;
      logic [1:0] sb, ps;
      alu = 3'b000; sa = 0; sb = 2'b00; ps = 2'b00; iord = 0; rd = 0; m2r = 0;
      irw = 0; mwr = 0; rw = 0; pcw = 0; pce = 0; ill = 0;
      if (in_rst) begin
         sb = 2'b01; alu = 3'b010;
      end else begin
         case (st)
            0:    begin sb = 2'b01; alu = 3'b010; irw = last; pcw = last; end
            1:    begin sb = 2'b11; alu = 3'b010; ill = !is_legal(op); end
            2, 9: begin sa = 1; sb = 2'b10; alu = 3'b010; end
            3:    iord = 1;
            4:    begin rw = 1; m2r = 1; end
            5:    begin iord = 1; mwr = 1; end
            6:    begin sa = 1; alu = funct_alu(fn); end
            7:    begin rw = 1; rd = 1; end
            8:    begin sa = 1; alu = 3'b110; ps = 2'b01; pce = z; end
            10:   rw = 1;
            11:   begin ps = 2'b10; pcw = 1; end
            12:   begin sa = 1; alu = 3'b110; ps = 2'b01; pce = !z; end
            default: ;
         endcase
      end
      pce = pce | pcw;
      return {alu, sa, sb, ps, iord, rd, m2r, irw, mwr, rw, pce, ill, 4'(st)};
   endfunction

   task automatic push(input int st, input int n);
      for (int k = 0; k < n; k++) begin
         q_st.push_back(st);
         q_last.push_back(k == n - 1);
      end
   endtask

   task automatic set_rst(input logic v);
      if (sel) rst2 = v;
      else     rst0 = v;
   endtask

   // Run one instruction through the selected instance; abort_at >= 0 asserts reset
   // during that cycle of the instruction and abandons it.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int abort_at);
      int w;
      logic [19:0] got;
      w = sel ? 2 : 0;
      q_st.delete();
      q_last.delete();
      push(0, w + 1);
      push(1, 1);
      case (op)
         6'h00: begin push(6, 1); push(7, 1); end
         6'h23: begin push(2, 1); push(3, w + 1); push(4, 1); end
         6'h2B: begin push(2, 1); push(5, w + 1); end
         6'h04: push(8, 1);
         6'h08: begin push(9, 1); push(10, 1); end
         6'h02: push(11, 1);
`ifdef MIPS_CTRL_BNE_EN
         6'h05: push(12, 1);
`endif
         default: ;
      endcase
      opcode = op;
      funct  = fn;
      for (int i = 0; i < q_st.size(); i++) begin
         zero = 1'($urandom_range(0, 1));
         if (i == abort_at) set_rst(1'b0);
         @(negedge clk);
         got = sel ? out2 : out0;
         check($sformatf("mw%0d op%02h fn%02h st%0d cyc%0d", w, op, fn, q_st[i], i),
               got, exp_vec(q_st[i], q_last[i], op, fn, zero, i == abort_at));
         @(posedge clk);
         #1;
         if (i == abort_at) begin
            set_rst(1'b1);
            return;
         end
      end
   endtask

   function automatic logic [5:0] rand_op();
      logic [5:0] ops [8];
      ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h05, 6'h3F};
      if ($urandom_range(0, 7) == 0) return 6'($urandom_range(0, 63));
      return ops[$urandom_range(0, 7)];
   endfunction

   function automatic logic [5:0] rand_fn();
      logic [5:0] fns [5];
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
      if ($urandom_range(0, 5) == 0) return 6'($urandom_range(0, 63));
      return fns[$urandom_range(0, 4)];
   endfunction

   initial begin
      rst0 = 1'b0; rst2 = 1'b0; opcode = '0; funct = '0; zero = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      zero = 1'b1;
      @(negedge clk);
      check("reset mw0", out0, exp_vec(0, 0, 6'h00, 6'h00, 1'b1, 1'b1));
      check("reset mw2", out2, exp_vec(0, 0, 6'h00, 6'h00, 1'b1, 1'b1));
      @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         sel = (s == 1);
         set_rst(1'b1);
         run_instr(6'h00, 6'h20, -1);
         run_instr(6'h00, 6'h22, -1);
         run_instr(6'h00, 6'h2A, -1);
         run_instr(6'h00, 6'h3F, -1);
         run_instr(6'h23, 6'h00, -1);
         run_instr(6'h2B, 6'h00, -1);
         run_instr(6'h04, 6'h00, -1);
         run_instr(6'h04, 6'h00, -1);
         run_instr(6'h08, 6'h00, -1);
         run_instr(6'h02, 6'h00, -1);
         run_instr(6'h3F, 6'h00, -1);
         run_instr(6'h05, 6'h00, -1);
         run_instr(6'h05, 6'h00, -1);
         run_instr(6'h2B, 6'h00, sel ? 5 : 3);
         run_instr(6'h00, 6'h25, -1);
         for (int n = 0; n < 150; n++) begin
            run_instr(rand_op(), rand_fn(),
                      ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1);
         end
         run_instr(6'h02, 6'h00, -1);
         @(negedge clk);
         check($sformatf("idle fetch sel%0d", s), sel ? out2 : out0,
               exp_vec(0, !sel, opcode, funct, zero, 1'b0));
         @(posedge clk);
         #1;
         set_rst(1'b0);
         @(posedge clk);
         #1;
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
